// File: rtl/seq_divider_32_pkg.sv
// Shared types and constants for the iterative divider.
// State encoding, iteration count and divide-by-zero quotient.
package seq_divider_32_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ADDSUB_32.sv
// 32-bit adder/subtractor: S = X + Y (Sub=0) or X - Y (Sub=1).
// Ports: X, Y operands, Sub mode, S result, Cout carry (1 = no borrow when subtracting).
module ADDSUB_32 (
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        Sub,
  output logic [31:0] S,
  output logic        Cout
);

  logic [31:0] yx;

  assign yx = Y ^ {32{Sub}};
  assign {Cout, S} = {1'b0, X} + {1'b0, yx} + {32'd0, Sub};

endmodule

// File: rtl/seq_divider_32.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU), one trial subtract per cycle.
// Ports: clk, rst, start, signed_op, dividend, divisor -> busy, done, quotient, remainder, div_by_zero.
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [4:0] LAST = 5'(DIV_ITERS - 1);

  state_t           state;
  logic             sop_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [4:0]       cnt;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             accept;

  assign a_neg = sop_q & a_q[WIDTH-1];
  assign b_neg = sop_q & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  assign rs = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  ADDSUB_32 u_addsub (
    .X    (rs),
    .Y    (dvs_q),
    .Sub  (1'b1),
    .S    (s),
    .Cout (cout)
  );

  // r_q[31] is the 33rd bit of the shifted remainder: it always fits.
  assign accept = r_q[WIDTH-1] | cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      sop_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      dvs_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q         <= dividend;
            b_q         <= divisor;
            sop_q       <= signed_op;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= S_PREP;
          end
        end
        S_PREP: begin
          if (b_q == '0) begin
            quotient    <= DIV0_QUOTIENT;
            remainder   <= a_q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            dvs_q  <= b_mag;
            q_q    <= a_mag;
            r_q    <= '0;
            cnt    <= '0;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            state  <= S_ITER;
          end
        end
        S_ITER: begin
          if (accept) begin
            r_q <= s;
            q_q <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_q <= rs;
            q_q <= {q_q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          quotient  <= qneg_q ? -q_q : q_q;
          remainder <= rneg_q ? -r_q : r_q;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed self-checking bench for seq_divider_32.
// Checks latency, busy window, single done pulse, results and async reset abort.
module tb_seq_divider_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors;
  int checks;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at edge 0; cycle c is the cycle after edge c-1.
  task automatic do_op(input string tag, input logic sop,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input int elat, input int pulse);
    int          dcyc;
    int          ndone;
    logic        bok;
    logic [31:0] oq;
    logic [31:0] orr;
    logic        odz;
    dcyc  = 0;
    ndone = 0;
    bok   = 1'b1;
    oq    = '0;
    orr   = '0;
    odz   = 1'b0;
    @(negedge clk);
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = ~sop;
    for (int c = 1; c <= elat + 3; c++) begin
      @(negedge clk);
      if (c == pulse) begin
        start    = 1'b1;
        dividend = 32'd1;
        divisor  = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = c;
          oq   = quotient;
          orr  = remainder;
          odz  = div_by_zero;
        end
      end
      if (busy !== (c <= elat)) bok = 1'b0;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(dcyc), 32'(elat));
    chk({tag, " ndone"}, 32'(ndone), 32'd1);
    chk({tag, " busy"}, {31'd0, bok}, 32'd1);
    chk({tag, " quotient"}, oq, eq);
    chk({tag, " remainder"}, orr, er);
    chk({tag, " dz"}, {31'd0, odz}, {31'd0, edz});
  endtask

  initial begin
    int nd;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst quotient", quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    chk("rst dz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    do_op("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35, 0);
    do_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35, 0);
    do_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE,
          32'hFFFF_FFFD, 32'd1, 1'b0, 35, 0);
    do_op("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
          32'd14, 32'hFFFF_FFFE, 1'b0, 35, 0);
    do_op("uFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'd1,
          32'hFFFF_FFFF, 32'd0, 1'b0, 35, 0);
    do_op("uFFFF/8..1", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001,
          32'd1, 32'h7FFF_FFFE, 1'b0, 35, 0);
    do_op("u5/0", 1'b0, 32'd5, 32'd0,
          32'hFFFF_FFFF, 32'd5, 1'b1, 2, 0);
    do_op("s5/0", 1'b1, 32'd5, 32'd0,
          32'hFFFF_FFFF, 32'd5, 1'b1, 2, 0);
    do_op("dz clear", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35, 0);
    do_op("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 32'd0, 1'b0, 35, 10);

    // Async reset in the middle of cycle 12 of a 100/7.
    @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst quotient", quotient, 32'd0);
    chk("arst remainder", remainder, 32'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3) rst = 1'b0;
      if (done) nd++;
    end
    chk("arst nodone", 32'(nd), 32'd0);

    do_op("u9/4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 35, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider_32.md
Name: seq_divider_32

Overview:
- Iterative 32-bit restoring divider for the CPU execute stage.
- Feeds operands to the existing ADDSUB_32 adder/subtractor in subtract mode, one trial subtraction per cycle, and consumes its S/Cout.
- Serves DIV/DIVU/REM/REMU. Control asserts start and stalls on busy until done.

Parameters:
- WIDTH, 32, operand width. Fixed at 32 to match ADDSUB_32. Other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin operation. Sampled only when busy=0.
- signed_op  in  1  1 = two's-complement division, 0 = unsigned. Captured with start.
- dividend  in  32  captured with start
- divisor  in  32  captured with start
- busy  out  1  high while an operation is in progress (state != IDLE)
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  32  held until next accepted start
- remainder  out  32  held until next accepted start
- div_by_zero  out  1  set with done when the captured divisor == 0. Held like the results.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; iteration counter = 0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: on start=1, capture operands and signed_op, go to PREP. Clear div_by_zero at capture. start=0 stays in IDLE.
- PREP (1 cycle):
  - divisor==0 goes to DONE with quotient=32'hFFFFFFFF, remainder=dividend (raw), div_by_zero=1.
  - Otherwise form magnitudes: if signed_op and operand[31], negate (two's complement). Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend), both signed only.
  - Load partial remainder R=0, Q=|dividend|, counter=0. Go to ITER.
- ITER (exactly 32 cycles, counter 0..31):
  - Rs = {R[30:0], Q[31]}. Adder inputs: X=Rs, Y=|divisor|, Sub=1.
  - Accept iff R[31]==1 OR Cout==1. R[31] covers the 33rd bit of the shifted remainder; Cout==1 means no borrow.
  - On accept: R <= S, Q <= {Q[30:0],1}. Otherwise: R <= Rs, Q <= {Q[30:0],0}.
  - After counter==31 go to FIX.
- FIX (1 cycle): quotient <= q_neg ? -Q : Q; remainder <= r_neg ? -R : R. Go to DONE.
- DONE (1 cycle): done=1, busy=1. Next state IDLE unconditionally.
- Latency:
  - Start sampled at edge 0 gives done high in cycle 35 (PREP 1 + ITER 32 + FIX 1 + DONE).
  - Divide-by-zero gives done in cycle 2.
  - busy is high from cycle 1 through the done cycle.
- start while busy=1 is ignored; no queuing. Back-to-back throughput is 1 operation per 36 cycles.
- Signed overflow 0x80000000 / -1 gives quotient 0x80000000, remainder 0 as a natural result; no flag.
- Remainder sign follows dividend; quotient truncates toward zero.
- Reset mid-operation aborts immediately. Outputs return to reset values and no done is produced.
- Operand inputs may change freely after the start cycle; only captured copies are used.

Decomposition:
- Shared package:
  - state encoding constants S_IDLE=0, S_PREP=1, S_ITER=2, S_FIX=3, S_DONE=4 (3 bits)
  - DIV_ITERS=32
  - DIV0_QUOTIENT=32'hFFFFFFFF
- Sub-module: a single ADDSUB_32 instance for the trial subtraction.
- Negations in PREP/FIX use plain inline two's complement; no second adder instance required.

Test Plan:
- Unsigned 100 / 7, signed_op=0 -> done at cycle 35, quotient=14, remainder=2, div_by_zero=0. busy high cycles 1..35.
- Signed -7 / 2 -> quotient=32'hFFFFFFFD (-3), remainder=32'hFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1.
- Unsigned 32'hFFFFFFFF / 1 and 32'hFFFFFFFF / 32'h80000001 (exercises the R[31] accept path) -> (FFFFFFFF, 0) and (1, 7FFFFFFE).
- Divide by zero 5 / 0 (both modes) -> done at cycle 2, quotient=FFFFFFFF, remainder=5, div_by_zero=1. Next normal op clears div_by_zero.
- Signed 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0. Start pulsed again at cycle 10 of this op -> ignored, single done.
- rst asserted asynchronously mid-cycle at cycle 12 of 100/7 -> busy, done, quotient, remainder drop to 0 at once, with no done pulse. A new start of 9/4 after release -> quotient=2, remainder=1 at cycle 35.
